// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the 32-bit ARM-subset core.
// A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback.
// It also holds the NZCV flag register and evaluates the condition field.
// Optional build macro MULTICYCLE_PERF_EN adds the CycleCnt/InstrCnt performance counters.

module multicycle_ctrl #(
  parameter int unsigned ALUCTRL_W = 3,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           Cond,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemW,
  output logic                 IRWrite,
  output logic                 RegW,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           Flags,
  output logic [3:0]           State
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [CNT_W-1:0]     CycleCnt,
  output logic [CNT_W-1:0]     InstrCnt
`endif
);

  // State encodings are visible on the State debug port, so they are fixed values.
  localparam logic [3:0] StFetch  = 4'd0;
  localparam logic [3:0] StDecode = 4'd1;
  localparam logic [3:0] StMemAdr = 4'd2;
  localparam logic [3:0] StMemRd  = 4'd3;
  localparam logic [3:0] StMemWb  = 4'd4;
  localparam logic [3:0] StMemWr  = 4'd5;
  localparam logic [3:0] StExecR  = 4'd6;
  localparam logic [3:0] StExecI  = 4'd7;
  localparam logic [3:0] StAluWb  = 4'd8;
  localparam logic [3:0] StBranch = 4'd9;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOrr = 3'b011;
  localparam logic [2:0] AluEor = 3'b100;

  // Elaboration-time sanity checks on the parameters.
  if (ALUCTRL_W < 3) begin : g_chk_aluctrl
    $error("ALUCTRL_W must be at least 3");
  end
  if (CNT_W < 1) begin : g_chk_cnt
    $error("CNT_W must be at least 1");
  end

  logic [3:0] state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic [2:0] dec_alu_op;
  logic [1:0] dec_flag_w;
  logic       dec_writes_reg;
  logic       cond_ex;
  logic       in_exec;
  logic       regw_raw;
  logic       pcwrite_raw;
  logic       irwrite_raw;
  logic       memw_raw;
  logic [2:0] alu_sel;

  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  assign in_exec = (state_q == StExecR) || (state_q == StExecI);

  // Next-state sequencing; illegal encodings fall back to FETCH.
  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        unique case (Op)
          2'b00:   state_d = Funct[5] ? StExecI : StExecR;
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = Funct[0] ? StMemRd : StMemWr;
      StMemRd:  state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = StFetch;
      StExecR:  state_d = StAluWb;
      StExecI:  state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // ALU command decode from Funct[4:1]; Funct[0] is the S bit.
  always_comb begin
    dec_alu_op     = AluAdd;
    dec_flag_w     = 2'b00;
    dec_writes_reg = 1'b0;
    unique case (Funct[4:1])
      4'b0100: begin
        dec_alu_op     = AluAdd;
        dec_flag_w     = {Funct[0], Funct[0]};
        dec_writes_reg = 1'b1;
      end
      4'b0010: begin
        dec_alu_op     = AluSub;
        dec_flag_w     = {Funct[0], Funct[0]};
        dec_writes_reg = 1'b1;
      end
      4'b0000: begin
        dec_alu_op     = AluAnd;
        dec_flag_w     = {Funct[0], 1'b0};
        dec_writes_reg = 1'b1;
      end
      4'b1100: begin
        dec_alu_op     = AluOrr;
        dec_flag_w     = {Funct[0], 1'b0};
        dec_writes_reg = 1'b1;
      end
      4'b0001: begin
        dec_alu_op     = AluEor;
        dec_flag_w     = {Funct[0], 1'b0};
        dec_writes_reg = 1'b1;
      end
      4'b1010: begin
        // CMP: subtract with implied S, result discarded.
        dec_alu_op     = AluSub;
        dec_flag_w     = 2'b11;
        dec_writes_reg = 1'b0;
      end
      default: begin
        dec_alu_op     = AluAdd;
        dec_flag_w     = 2'b00;
        dec_writes_reg = 1'b0;
      end
    endcase
  end

  // Condition evaluation against the registered flags.
  always_comb begin
    cond_ex = 1'b0;
    unique case (Cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Flags are only captured on the edge leaving an execute state.
  always_comb begin
    flags_d = flags_q;
    if (in_exec && cond_ex) begin
      if (dec_flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
      if (dec_flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  // State and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  // Moore datapath controls per state; anything not set stays 0.
  always_comb begin
    AdrSrc      = 1'b0;
    irwrite_raw = 1'b0;
    memw_raw    = 1'b0;
    regw_raw    = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    alu_sel     = AluAdd;
    unique case (state_q)
      StFetch: begin
        irwrite_raw = 1'b1;
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
      end
      StDecode: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StMemAdr: ALUSrcB = 2'b01;
      StMemRd:  AdrSrc = 1'b1;
      StMemWr: begin
        AdrSrc   = 1'b1;
        memw_raw = cond_ex;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        regw_raw  = cond_ex;
      end
      StExecR:  alu_sel = dec_alu_op;
      StExecI: begin
        ALUSrcB = 2'b01;
        alu_sel = dec_alu_op;
      end
      StAluWb:  regw_raw = cond_ex & dec_writes_reg;
      StBranch: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
      end
      default: ;
    endcase
  end

  // Writeback to R15 doubles as a jump.
  assign pcwrite_raw = (state_q == StFetch) ||
                       (cond_ex && ((state_q == StBranch) || (regw_raw && (Rd == 4'd15))));

  // Write enables are held low for as long as reset is asserted.
  assign PCWrite    = rst_n & pcwrite_raw;
  assign IRWrite    = rst_n & irwrite_raw;
  assign MemW       = rst_n & memw_raw;
  assign RegW       = rst_n & regw_raw;
  assign ImmSrc     = Op;
  assign RegSrc     = {(Op == 2'b01), (Op == 2'b10)};
  assign ALUControl = ALUCTRL_W'(alu_sel);
  assign Flags      = flags_q;
  assign State      = state_q;

`ifdef MULTICYCLE_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;
  logic             instr_done;

  assign instr_done = (state_q != StFetch) && (state_d == StFetch);

  // Free-running cycle counter and retired-instruction counter, both wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 1'b1;
      if (instr_done) instr_cnt_q <= instr_cnt_q + 1'b1;
    end
  end

  assign CycleCnt = cycle_cnt_q;
  assign InstrCnt = instr_cnt_q;
`else
  // No performance counters in this build.
`endif

endmodule
